// File: rtl/alu_pwr_pkg.sv
// Shared types and defaults for the ALU power-gating sequencer.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_RST_REL = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_ISO_ON  = 3'd4
  } pwr_state_e;

  localparam int unsigned DEF_PWR_UP_CYCLES = 8;
  localparam int unsigned DEF_ISO_SETUP     = 2;
  localparam int unsigned DEF_IDLE_TIMEOUT  = 64;
  localparam int unsigned DEF_CNT_W         = 8;

  // Domain control pins as seen by the power domain.
  typedef struct packed {
    logic pwr_en;
    logic iso_en;
    logic rst_n;
    logic ready;
  } dom_ctrl_t;

  // Fixed per-state drive. Isolation stays on whenever the domain is
  // unpowered or held in reset; only ACTIVE removes the clamp.
  function automatic dom_ctrl_t decode_state(input pwr_state_e s);
    dom_ctrl_t c;
    c = '{pwr_en: 1'b0, iso_en: 1'b1, rst_n: 1'b0, ready: 1'b0};
    case (s)
      ST_PWR_UP:  c = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b0, ready: 1'b0};
      ST_RST_REL: c = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b1, ready: 1'b0};
      ST_ACTIVE:  c = '{pwr_en: 1'b1, iso_en: 1'b0, rst_n: 1'b1, ready: 1'b1};
      ST_ISO_ON:  c = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b1, ready: 1'b0};
      default:    c = '{pwr_en: 1'b0, iso_en: 1'b1, rst_n: 1'b0, ready: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_pwr_ctrl_timer.sv
// Loadable down-counter shared by the power-up settle and isolation setup phases.
module pwr_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// ALU power-domain sequencer: OFF -> PWR_UP -> RST_REL -> ACTIVE -> ISO_ON -> OFF.
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int unsigned PWR_UP_CYCLES = DEF_PWR_UP_CYCLES,
  parameter int unsigned ISO_SETUP     = DEF_ISO_SETUP,
  parameter int unsigned IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_req,
  output logic       op_grant,
  input  logic       alu_busy,
  input  logic       sleep_req,
  input  logic       wake_req,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       alu_rst_n,
  output logic [2:0] pwr_state,
  output logic       ready
);

  // Timer is loaded with N-1 on the transition into a timed state, so the
  // state lasts exactly N cycles (it exits on the cycle the count is zero).
  localparam logic [CNT_W-1:0] PU_LOAD   = CNT_W'(PWR_UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LOAD  = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = (IDLE_TIMEOUT == 0) ? '0 : CNT_W'(IDLE_TIMEOUT - 1);

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  dom_ctrl_t        ctrl_q, ctrl_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;
  logic             idle_cyc;
  logic             idle_expired;

  pwr_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  // Next state, timer loads and idle counter; sleep_req dominates wake sources.
  always_comb begin
    state_d      = state_q;
    idle_d       = '0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    idle_cyc     = (state_q == ST_ACTIVE) && !op_req && !alu_busy;
    idle_expired = (IDLE_TIMEOUT != 0) && idle_cyc && (idle_q == IDLE_LAST);
    case (state_q)
      ST_OFF: begin
        if ((op_req || wake_req) && !sleep_req) begin
          state_d      = ST_PWR_UP;
          tmr_load     = 1'b1;
          tmr_load_val = PU_LOAD;
        end
      end
      ST_PWR_UP:  if (tmr_done) state_d = ST_RST_REL;
      ST_RST_REL: state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        // Saturate so a disabled timeout never wraps into a false expiry.
        if (idle_cyc) idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
        if (!alu_busy && (sleep_req || idle_expired)) begin
          state_d      = ST_ISO_ON;
          tmr_load     = 1'b1;
          tmr_load_val = ISO_LOAD;
        end
      end
      // Power-down always completes; new requests wait for OFF.
      ST_ISO_ON:  if (tmr_value == '0) state_d = ST_OFF;
      default:    state_d = ST_OFF;
    endcase
    ctrl_d = decode_state(state_d);
  end

  // State, idle count and decoded domain pins registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      idle_q  <= '0;
      ctrl_q  <= decode_state(ST_OFF);
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Grant is combinational so the requester can start in the same cycle.
  assign op_grant   = rst_n && (state_q == ST_ACTIVE) && op_req && !alu_busy && !sleep_req;
  assign alu_pwr_en = ctrl_q.pwr_en;
  assign iso_en     = ctrl_q.iso_en;
  assign alu_rst_n  = ctrl_q.rst_n;
  assign ready      = ctrl_q.ready;
  assign pwr_state  = state_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Scoreboard bench for alu_pwr_ctrl at default parameters.
module tb_alu_pwr_ctrl;

  localparam int P   = 8;
  localparam int ISO = 2;
  localparam int IT  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, op_req, alu_busy, sleep_req, wake_req;
  logic       op_grant, alu_pwr_en, iso_en, alu_rst_n, ready;
  logic [2:0] pwr_state;

  alu_pwr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_req(op_req), .op_grant(op_grant),
    .alu_busy(alu_busy), .sleep_req(sleep_req), .wake_req(wake_req),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .alu_rst_n(alu_rst_n),
    .pwr_state(pwr_state), .ready(ready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s_cyc = 0;

  logic rst_i = 1'b0, op_i = 1'b0, busy_i = 1'b0, slp_i = 1'b0, wk_i = 1'b0;
  logic [2:0] s_state;
  logic s_pwr, s_iso, s_rstn, s_ready, s_grant;

  int m_st = 0, m_el = 0, m_idle = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, s_cyc);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [2:0] st;
    st = 3'(m_st);
    return {st, 1'(m_st != 0), 1'(m_st != 3), 1'(m_st >= 2), 1'(m_st == 3),
            1'(rst_i && m_st == 3 && op_i && !busy_i && !slp_i)};
  endfunction

  task automatic model_step();
    logic idle;
    if (!rst_i) begin
      m_st = 0; m_el = 0; m_idle = 0;
    end else begin
      case (m_st)
        0: if ((op_i || wk_i) && !slp_i) begin m_st = 1; m_el = 1; end
        1: if (m_el == P) m_st = 2; else m_el++;
        2: begin m_st = 3; m_idle = 0; end
        3: begin
          idle = !op_i && !busy_i;
          if (!busy_i && (slp_i || (IT != 0 && idle && m_idle + 1 == IT))) begin
            m_st = 4; m_el = 1;
          end
          m_idle = idle ? m_idle + 1 : 0;
        end
        default: if (m_el == ISO) m_st = 0; else m_el++;
      endcase
    end
  endtask

  // One cycle: drive inputs at the falling edge, sample after settle, score, advance model.
  task automatic tick();
    logic [7:0] got;
    @(negedge clk);
    rst_n = rst_i; op_req = op_i; alu_busy = busy_i; sleep_req = slp_i; wake_req = wk_i;
    #1;
    exp_q.push_back(model_out());
    s_cyc = cyc;
    s_state = pwr_state; s_pwr = alu_pwr_en; s_iso = iso_en;
    s_rstn = alu_rst_n; s_ready = ready; s_grant = op_grant;
    got = {s_state, s_pwr, s_iso, s_rstn, s_ready, s_grant};
    chk("scoreboard", got, exp_q.pop_front());
    chk("iso_invariant", s_iso | (s_pwr & s_rstn), 1);
    chk("grant_legal", !s_grant || (s_state == 3 && !busy_i), 1);
    model_step();
    cyc++;
  endtask

  task automatic wait_state(input int st, input int maxc, input string tag);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (s_state == 3'(st)) return;
    end
    chk(tag, s_state, st);
  endtask

  int c0, t_a, t_b, t_c;

  initial begin
    rst_n = 1'b0; op_req = 1'b0; alu_busy = 1'b0; sleep_req = 1'b0; wake_req = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    tick();
    chk("reset_pins", {s_state, s_pwr, s_iso, s_rstn, s_ready, s_grant}, 8'b000_0_1_0_0_0);

    // Wake latency from OFF
    rst_i = 1'b1; op_i = 1'b1;
    c0 = cyc; t_a = -1; t_b = -1; t_c = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (s_pwr  && t_a < 0) t_a = s_cyc - c0;
      if (s_rstn && t_b < 0) t_b = s_cyc - c0;
      if (s_grant && t_c < 0) begin
        t_c = s_cyc - c0;
        chk("wake_iso_low", s_iso, 0);
      end
    end
    chk("wake_pwr_rise", t_a, 1);
    chk("wake_rst_rise", t_b, 9);
    chk("wake_grant", t_c, 10);

    // Auto power-down from continuous idle
    op_i = 1'b0; c0 = cyc; t_a = -1; t_b = -1;
    for (int k = 0; k < 90 && t_b < 0; k++) begin
      tick();
      if (s_state == 4 && t_a < 0) t_a = s_cyc - c0;
      if (s_state == 0 && t_a >= 0 && t_b < 0) t_b = s_cyc - c0;
    end
    chk("idle_iso_at", t_a, IT);
    chk("idle_off_at", t_b, IT + ISO);

    // Idle count restarted by a single op at cycle 30
    op_i = 1'b1;
    wait_state(3, 20, "rewake_to_active");
    c0 = cyc; t_a = -1; t_b = -1;
    for (int k = 0; k < 120 && t_b < 0; k++) begin
      op_i = (k == 30);
      tick();
      if (s_state == 4 && t_a < 0) t_a = s_cyc - c0;
      if (s_state == 0 && t_a >= 0 && t_b < 0) t_b = s_cyc - c0;
    end
    chk("restart_iso_at", t_a, 30 + IT + 1);
    chk("restart_off_at", t_b, 30 + IT + ISO + 1);

    // Sleep while busy holds ACTIVE without grants
    op_i = 1'b1;
    wait_state(3, 20, "busy_to_active");
    busy_i = 1'b1; slp_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("slp_busy_state", s_state, 3);
      chk("slp_busy_grant", s_grant, 0);
    end
    busy_i = 1'b0;
    tick();
    chk("slp_drop_state", s_state, 3);
    tick();
    chk("slp_iso_entry", s_state, 4);

    // op_req during ISO_ON completes power-down, then re-wakes
    slp_i = 1'b0; op_i = 1'b1;
    c0 = s_cyc; t_a = -1; t_b = -1; t_c = -1;
    for (int k = 0; k < 30 && t_c < 0; k++) begin
      tick();
      if (s_state == 0 && t_a < 0) t_a = s_cyc - c0;
      if (s_state == 1 && t_b < 0) t_b = s_cyc - c0;
      if (s_grant && t_c < 0) t_c = s_cyc - c0;
    end
    chk("iso_req_off_at", t_a, ISO);
    chk("iso_req_pwrup_at", t_b, ISO + 1);
    chk("iso_req_grant_lat", t_c - t_a, P + 2);

    // sleep_req keeps OFF despite op_req
    op_i = 1'b0; slp_i = 1'b1;
    wait_state(0, 10, "sleep_to_off");
    op_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sleep_hold_off", {s_state, s_pwr}, 4'b000_0);
    end
    slp_i = 1'b0;
    tick();
    tick();
    chk("sleep_release_pwrup", s_state, 1);

    // Reset on PWR_UP cycle 4
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("pwrup4_state", s_state, 1);
    rst_i = 1'b1;
    tick();
    chk("rst_mid_pins", {s_state, s_pwr, s_iso, s_rstn}, 6'b000_0_1_0);

    // Reset while ACTIVE with a pending op masks the grant
    wait_state(3, 20, "rst_to_active");
    rst_i = 1'b0;
    tick();
    chk("rst_grant_mask", s_grant, 0);
    rst_i = 1'b1; op_i = 1'b0;
    tick();
    chk("rst_active_state", s_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pwr_ctrl.md
# alu_pwr_ctrl

Power-gating sequencer for the ALU power domain. It drives the domain's `alu_pwr_en`, `iso_en` and a domain reset in a fixed safe order, and wakes the domain on demand. It grants operation requests only when the ALU is powered, out of reset and de-isolated, and powers the domain down after a programmable idle period or on a software sleep request. It sits beside the ALU wrapper and replaces the free-running `alu_pwr_en`/`iso_en` inputs.

## Interface
- `PWR_UP_CYCLES`, default 8: cycles `alu_pwr_en` is held high with reset asserted before reset release (rail settle). Minimum 1.
- `ISO_SETUP`, default 2: cycles isolation is held with power still on before power is removed. Minimum 1.
- `IDLE_TIMEOUT`, default 64: consecutive idle ACTIVE cycles before auto power-down. A value of 0 disables auto power-down.
- `CNT_W`, default 8: timer width. Must hold max(`PWR_UP_CYCLES`, `ISO_SETUP`, `IDLE_TIMEOUT`).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `op_req`  in  1  requester wants to issue an ALU op (level; held until granted).
- `op_grant`  out  1  combinational; requester may pulse ALU `start` this cycle.
- `alu_busy`  in  1  ALU busy flag.
- `sleep_req`  in  1  software forced sleep (level).
- `wake_req`  in  1  software wake (level) without a pending op.
- `alu_pwr_en`  out  1  domain power switch enable.
- `iso_en`  out  1  output isolation/clamp enable.
- `alu_rst_n`  out  1  domain reset, active-low.
- `pwr_state`  out  3  current state encoding.
- `ready`  out  1  high in ACTIVE.

## Operation
- States and encodings: OFF=0, PWR_UP=1, RST_REL=2, ACTIVE=3, ISO_ON=4. All outputs except `op_grant` are registered and decoded from state.
- OFF: `alu_pwr_en`=0, `iso_en`=1, `alu_rst_n`=0. Transitions to PWR_UP when (`op_req` | `wake_req`) & !`sleep_req`.
- PWR_UP: `alu_pwr_en`=1, `iso_en`=1, `alu_rst_n`=0 for exactly `PWR_UP_CYCLES` cycles, then RST_REL.
- RST_REL: `alu_pwr_en`=1, `iso_en`=1, `alu_rst_n`=1 for one cycle, then ACTIVE.
- ACTIVE: `alu_pwr_en`=1, `iso_en`=0, `alu_rst_n`=1, `ready`=1.
- `op_grant` = ACTIVE & `op_req` & !`alu_busy` & !`sleep_req`.
- Idle cycle = ACTIVE & !`op_req` & !`alu_busy`. The idle counter increments on idle cycles and clears on any non-idle cycle and on entry to ACTIVE.
- ACTIVE→ISO_ON when !`alu_busy` & (`sleep_req` | (`IDLE_TIMEOUT`≠0 & the idle counter reaches `IDLE_TIMEOUT`−1 on an idle cycle)).
- ISO_ON: `alu_pwr_en`=1, `iso_en`=1, `alu_rst_n`=1 for `ISO_SETUP` cycles, then OFF.
- Invariant: `iso_en`=1 whenever `alu_pwr_en`=0 or `alu_rst_n`=0.
- `sleep_req` has priority over `op_req`/`wake_req` in every state. While asserted, no grant is issued and OFF is not left.
- Power-down is never aborted. An `op_req` arriving in ISO_ON completes the sequence to OFF, then re-wakes from OFF.
- `sleep_req` while `alu_busy`: remain in ACTIVE, without granting, until busy falls.

## Timing
- Reset, on any cycle including mid-sequence: state OFF, `alu_pwr_en`=0, `iso_en`=1, `alu_rst_n`=0, `ready`=0, `op_grant`=0, counters 0.
- Wake latency: with `op_req` first seen in OFF at cycle 0, PWR_UP covers cycles 1..`PWR_UP_CYCLES`, RST_REL is cycle `PWR_UP_CYCLES`+1, and the first `op_grant` is at cycle `PWR_UP_CYCLES`+2 (10 at defaults).
- Auto-sleep: with the last non-idle cycle at t, ISO_ON is entered at t+`IDLE_TIMEOUT`+1 and OFF at t+`IDLE_TIMEOUT`+`ISO_SETUP`+1.
- Sleep latency with the ALU idle: `sleep_req` seen at cycle 0 in ACTIVE gives ISO_ON at cycle 1 and OFF at cycle 1+`ISO_SETUP`.

## Structure
- Package `alu_pwr_pkg`: state enum and encodings, default parameter constants.
- Sub-module `pwr_timer`: loadable down-counter with `load`, `value`, and `done` (count==0). It is shared by PWR_UP and ISO_ON. The idle counter is separate and lives inline.

## Test plan
- Reset mid-PWR_UP (cycle 4 of 8) → next cycle state 0, `alu_pwr_en`=0, `iso_en`=1, `alu_rst_n`=0.
- `op_req` high in OFF at cycle 0 (defaults) → `alu_pwr_en` rises at cycle 1, `alu_rst_n` rises at cycle 9, `iso_en` falls and `op_grant`=1 at cycle 10.
- ACTIVE, idle from cycle 0, `IDLE_TIMEOUT`=64 → ISO_ON at cycle 64, OFF at cycle 66. A single `op_req` at cycle 30 restarts the count.
- `sleep_req` asserted with `alu_busy`=1 for 5 cycles → no grant, state stays ACTIVE, ISO_ON the cycle after busy drops.
- `op_req` raised during ISO_ON → sequence reaches OFF, then PWR_UP next cycle, grant `PWR_UP_CYCLES`+2 cycles after OFF.
- Every cycle across all scenarios → assert the `iso_en` invariant, and assert `op_grant` only when state=3 and `alu_busy`=0.
